// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types, forward-select codes and register-compare
//                helpers for the RV32 pipeline hazard controller.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // x0 is hardwired to zero, so it can never be the subject of a hazard.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic src_hit(input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        return we && (reg_match(rd, rs1) || reg_match(rd, rs2));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Pipeline taps into, and stall/flush/forward controls out of,
//                the hazard controller. slave = controller, master = pipeline.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1n_ID;
    logic [4:0]       rs2n_ID;
    logic [4:0]       rs1n_EX;
    logic [4:0]       rs2n_EX;
    logic [4:0]       rdn_EX;
    logic             RegWrite_EX;
    logic             MemToReg_EX;
    logic [4:0]       rdn_MEM;
    logic             RegWrite_MEM;
    logic [4:0]       rdn_WB;
    logic             RegWrite_WB;
    logic             Redirect_EX;
    logic             StallIF;
    logic             StallID;
    logic             EnableID;
    logic             FlushD;
    logic             FlushE;
    logic [1:0]       FwdA_EX;
    logic [1:0]       FwdB_EX;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  rs1n_ID, rs2n_ID, rs1n_EX, rs2n_EX, rdn_EX,
        input  RegWrite_EX, MemToReg_EX, rdn_MEM, RegWrite_MEM,
        input  rdn_WB, RegWrite_WB, Redirect_EX,
        output StallIF, StallID, EnableID, FlushD, FlushE,
        output FwdA_EX, FwdB_EX, stall_cnt, flush_cnt
    );

    modport master (
        output rs1n_ID, rs2n_ID, rs1n_EX, rs2n_EX, rdn_EX,
        output RegWrite_EX, MemToReg_EX, rdn_MEM, RegWrite_MEM,
        output rdn_WB, RegWrite_WB, Redirect_EX,
        input  StallIF, StallID, EnableID, FlushD, FlushE,
        input  FwdA_EX, FwdB_EX, stall_cnt, flush_cnt
    );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Load-use/RAW stall, redirect flush and EX forwarding control
//                for the 5-stage RV32 core. Define HAZARD_FWD_EN to enable
//                operand forwarding (otherwise RAW hazards stall).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_fcnt;
    logic [1:0] w_fcnt_nxt;
    logic       w_flush;
    logic       w_lu;
    logic       w_hazard;
    logic       w_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_fcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_flush     = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.Redirect_EX) begin
                    w_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = FLUSH;
                        w_fcnt_nxt  = 2'(FLUSH_CYCLES - 1);
                    end
                end
            end
            FLUSH: begin
                // Further redirects are shadowed: the flushed slots hold no real branches.
                w_flush    = 1'b1;
                w_fcnt_nxt = r_fcnt - 2'd1;
                if (r_fcnt <= 2'd1) begin
                    w_state_nxt = RUN;
                    w_fcnt_nxt  = 2'd0;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_fcnt_nxt  = 2'd0;
            end
        endcase
    end

    assign w_lu = bus.MemToReg_EX &&
                  src_hit(bus.RegWrite_EX, bus.rdn_EX, bus.rs1n_ID, bus.rs2n_ID);

`ifdef HAZARD_FWD_EN
    assign w_hazard = w_lu;

    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (bus.RegWrite_MEM && reg_match(bus.rdn_MEM, bus.rs1n_EX)) begin
            w_fwd_a = FWD_MEM;
        end else if (bus.RegWrite_WB && reg_match(bus.rdn_WB, bus.rs1n_EX)) begin
            w_fwd_a = FWD_WB;
        end
        if (bus.RegWrite_MEM && reg_match(bus.rdn_MEM, bus.rs2n_EX)) begin
            w_fwd_b = FWD_MEM;
        end else if (bus.RegWrite_WB && reg_match(bus.rdn_WB, bus.rs2n_EX)) begin
            w_fwd_b = FWD_WB;
        end
    end
`else
    // WB is included because the register file returns the pre-write value.
    assign w_hazard = w_lu ||
                      src_hit(bus.RegWrite_EX,  bus.rdn_EX,  bus.rs1n_ID, bus.rs2n_ID) ||
                      src_hit(bus.RegWrite_MEM, bus.rdn_MEM, bus.rs1n_ID, bus.rs2n_ID) ||
                      src_hit(bus.RegWrite_WB,  bus.rdn_WB,  bus.rs1n_ID, bus.rs2n_ID);
    assign w_fwd_a  = FWD_RF;
    assign w_fwd_b  = FWD_RF;
`endif

    // A redirect must let the PC load its target, so it suppresses the stall.
    assign w_stall      = w_hazard && !w_flush;

    assign bus.StallIF  = w_stall;
    assign bus.StallID  = w_stall;
    assign bus.EnableID = !w_stall;
    assign bus.FlushD   = w_flush;
    assign bus.FlushE   = w_flush || w_hazard;
    assign bus.FwdA_EX  = w_fwd_a;
    assign bus.FwdB_EX  = w_fwd_b;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stall),
        .o_count (bus.stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_flush),
        .o_count (bus.flush_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed bench for hazard_ctrl: a 2-cycle-flush/32-bit DUT
//                and a 1-cycle-flush/4-bit DUT share the same stimulus.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    typedef struct packed {
        logic       sif;
        logic       sid;
        logic       en;
        logic       fd;
        logic       fe;
        logic [1:0] fa;
        logic [1:0] fb;
    } ctl_t;

    localparam ctl_t C_IDLE  = '{sif: 1'b0, sid: 1'b0, en: 1'b1, fd: 1'b0, fe: 1'b0, fa: 2'b00, fb: 2'b00};
    localparam ctl_t C_STALL = '{sif: 1'b1, sid: 1'b1, en: 1'b0, fd: 1'b0, fe: 1'b1, fa: 2'b00, fb: 2'b00};
    localparam ctl_t C_FLUSH = '{sif: 1'b0, sid: 1'b0, en: 1'b1, fd: 1'b1, fe: 1'b1, fa: 2'b00, fb: 2'b00};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1n_ID = '0, rs2n_ID = '0, rs1n_EX = '0, rs2n_EX = '0, rdn_EX = '0;
    logic [4:0] rdn_MEM = '0, rdn_WB = '0;
    logic       RegWrite_EX = 1'b0, MemToReg_EX = 1'b0, RegWrite_MEM = 1'b0;
    logic       RegWrite_WB = 1'b0, Redirect_EX = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    ctl_t  exp_q[$];
    string tag_q[$];
    logic [31:0] m_stall_a = '0, m_flush_a = '0;
    logic [3:0]  m_stall_b = '0, m_flush_b = '0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(32)) bus_a ();
    hazard_ctrl_if #(.CNT_W(4))  bus_b ();

    assign bus_a.rs1n_ID = rs1n_ID;        assign bus_b.rs1n_ID = rs1n_ID;
    assign bus_a.rs2n_ID = rs2n_ID;        assign bus_b.rs2n_ID = rs2n_ID;
    assign bus_a.rs1n_EX = rs1n_EX;        assign bus_b.rs1n_EX = rs1n_EX;
    assign bus_a.rs2n_EX = rs2n_EX;        assign bus_b.rs2n_EX = rs2n_EX;
    assign bus_a.rdn_EX = rdn_EX;          assign bus_b.rdn_EX = rdn_EX;
    assign bus_a.RegWrite_EX = RegWrite_EX;   assign bus_b.RegWrite_EX = RegWrite_EX;
    assign bus_a.MemToReg_EX = MemToReg_EX;   assign bus_b.MemToReg_EX = MemToReg_EX;
    assign bus_a.rdn_MEM = rdn_MEM;        assign bus_b.rdn_MEM = rdn_MEM;
    assign bus_a.RegWrite_MEM = RegWrite_MEM; assign bus_b.RegWrite_MEM = RegWrite_MEM;
    assign bus_a.rdn_WB = rdn_WB;          assign bus_b.rdn_WB = rdn_WB;
    assign bus_a.RegWrite_WB = RegWrite_WB;   assign bus_b.RegWrite_WB = RegWrite_WB;
    assign bus_a.Redirect_EX = Redirect_EX;   assign bus_b.Redirect_EX = Redirect_EX;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4))  u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    ctl_t obs_a, obs_b;
    assign obs_a = '{sif: bus_a.StallIF, sid: bus_a.StallID, en: bus_a.EnableID, fd: bus_a.FlushD,
                     fe: bus_a.FlushE, fa: bus_a.FwdA_EX, fb: bus_a.FwdB_EX};
    assign obs_b = '{sif: bus_b.StallIF, sid: bus_b.StallID, en: bus_b.EnableID, fd: bus_b.FlushD,
                     fe: bus_b.FlushE, fa: bus_b.FwdA_EX, fb: bus_b.FwdB_EX};

    function automatic ctl_t fwd(input logic [1:0] fa, input logic [1:0] fb);
        ctl_t c;
        c    = C_IDLE;
        c.fa = fa;
        c.fb = fb;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: queue expectations, compare at negedge, then advance the counter model.
    task automatic step(input string tag, input ctl_t ea, input ctl_t eb);
        ctl_t  pa, pb;
        string t;
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        tag_q.push_back(tag);
        @(negedge clk);
        pa = exp_q.pop_front();
        pb = exp_q.pop_front();
        t  = tag_q.pop_front();
        chk({t, "/ctl_a"}, 32'(obs_a), 32'(pa));
        chk({t, "/ctl_b"}, 32'(obs_b), 32'(pb));
        chk({t, "/stall_cnt_a"}, bus_a.stall_cnt, m_stall_a);
        chk({t, "/flush_cnt_a"}, bus_a.flush_cnt, m_flush_a);
        chk({t, "/stall_cnt_b"}, 32'(bus_b.stall_cnt), 32'(m_stall_b));
        chk({t, "/flush_cnt_b"}, 32'(bus_b.flush_cnt), 32'(m_flush_b));
        @(posedge clk);
        if (rst) begin
            m_stall_a = '0; m_flush_a = '0; m_stall_b = '0; m_flush_b = '0;
        end else begin
            m_stall_a = m_stall_a + 32'(pa.sif);
            m_flush_a = m_flush_a + 32'(pa.fd);
            if (pb.sif && m_stall_b != 4'hF) m_stall_b = m_stall_b + 4'd1;
            if (pb.fd  && m_flush_b != 4'hF) m_flush_b = m_flush_b + 4'd1;
        end
        #1;
    endtask

    task automatic clear_inputs();
        rs1n_ID = '0; rs2n_ID = '0; rs1n_EX = '0; rs2n_EX = '0; rdn_EX = '0;
        rdn_MEM = '0; rdn_WB = '0; RegWrite_EX = 1'b0; MemToReg_EX = 1'b0;
        RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0; Redirect_EX = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) step("idle", C_IDLE, C_IDLE);

        // Forwarding: MEM wins over WB, WB alone, x0 never forwards
        rdn_MEM = 5'd5; RegWrite_MEM = 1'b1; rdn_WB = 5'd5; RegWrite_WB = 1'b1; rs1n_EX = 5'd5;
        step("fwd_mem", FWD_ON ? fwd(FWD_MEM, FWD_RF) : C_IDLE, FWD_ON ? fwd(FWD_MEM, FWD_RF) : C_IDLE);
        RegWrite_MEM = 1'b0;
        step("fwd_wb", FWD_ON ? fwd(FWD_WB, FWD_RF) : C_IDLE, FWD_ON ? fwd(FWD_WB, FWD_RF) : C_IDLE);
        rs2n_EX = 5'd5;
        step("fwd_wb_ab", FWD_ON ? fwd(FWD_WB, FWD_WB) : C_IDLE, FWD_ON ? fwd(FWD_WB, FWD_WB) : C_IDLE);
        rs1n_EX = 5'd0; rdn_WB = 5'd0; rs2n_EX = 5'd0;
        step("fwd_x0", C_IDLE, C_IDLE);
        clear_inputs();

        // Load-use bubble, then x0 load destination never stalls
        rdn_EX = 5'd7; MemToReg_EX = 1'b1; RegWrite_EX = 1'b1; rs2n_ID = 5'd7;
        step("load_use", C_STALL, C_STALL);
        rs2n_ID = 5'd0;
        step("load_gone", C_IDLE, C_IDLE);
        rdn_EX = 5'd0;
        step("load_x0", C_IDLE, C_IDLE);
        clear_inputs();

        // Redirect: a holds 2 flush cycles and ignores the second pulse
        Redirect_EX = 1'b1;
        step("redir_1", C_FLUSH, C_FLUSH);
        step("redir_2", C_FLUSH, C_FLUSH);
        Redirect_EX = 1'b0;
        step("redir_end", C_IDLE, C_IDLE);
        Redirect_EX = 1'b1;
        step("pulse_1", C_FLUSH, C_FLUSH);
        Redirect_EX = 1'b0;
        step("pulse_2", C_FLUSH, C_IDLE);
        step("pulse_end", C_IDLE, C_IDLE);

        // Redirect together with load-use: flush wins
        Redirect_EX = 1'b1; rdn_EX = 5'd9; MemToReg_EX = 1'b1; RegWrite_EX = 1'b1; rs1n_ID = 5'd9;
        step("redir_lu", C_FLUSH, C_FLUSH);
        Redirect_EX = 1'b0;
        step("flush_lu", C_FLUSH, C_STALL);
        clear_inputs();
        step("redir_lu_end", C_IDLE, C_IDLE);

        // Reset in the middle of FLUSH
        Redirect_EX = 1'b1;
        step("pre_rst", C_FLUSH, C_FLUSH);
        Redirect_EX = 1'b0; rst = 1'b1;
        step("rst_mid_flush", C_FLUSH, C_IDLE);
        rst = 1'b0;
        step("post_rst", C_IDLE, C_IDLE);

        // RAW on WB/MEM/non-load EX stalls only without forwarding
        rdn_WB = 5'd3; RegWrite_WB = 1'b1; rs1n_ID = 5'd3;
        step("raw_wb", FWD_ON ? C_IDLE : C_STALL, FWD_ON ? C_IDLE : C_STALL);
        clear_inputs();
        rdn_MEM = 5'd4; RegWrite_MEM = 1'b1; rs2n_ID = 5'd4;
        step("raw_mem", FWD_ON ? C_IDLE : C_STALL, FWD_ON ? C_IDLE : C_STALL);
        clear_inputs();
        rdn_EX = 5'd6; RegWrite_EX = 1'b1; rs1n_ID = 5'd6;
        step("raw_ex", FWD_ON ? C_IDLE : C_STALL, FWD_ON ? C_IDLE : C_STALL);
        RegWrite_EX = 1'b0;
        step("raw_ex_nowr", C_IDLE, C_IDLE);
        clear_inputs();

        // 20 load-use stall cycles saturate the 4-bit counter at 15
        rdn_EX = 5'd8; MemToReg_EX = 1'b1; RegWrite_EX = 1'b1; rs1n_ID = 5'd8;
        for (int i = 0; i < 20; i++) step("sat_stall", C_STALL, C_STALL);
        clear_inputs();
        step("sat_end", C_IDLE, C_IDLE);
        chk("stall_cnt_b_sat", 32'(bus_b.stall_cnt), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core: the block that drives the core's `StallIF`, `StallID`, `EnableID` and `FlushE` inputs. It detects load-use and RAW hazards and branch/jump redirects from register numbers and control flags tapped at ID/EX/MEM/WB. It produces stall/flush controls and EX operand-forwarding selects. A small state machine sequences redirect flushes, and saturating counters record stall and flush cycles for performance checks.

## Interface
Parameters:
- `FLUSH_CYCLES`, 1: cycles FlushD/FlushE held after a redirect (1..3).
- `CNT_W`, 32: width of perf counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `rs1n_ID`, `rs2n_ID`  in  5 each  source regs of instruction in ID.
- `rs1n_EX`, `rs2n_EX`, `rdn_EX`  in  5 each  EX register numbers.
- `RegWrite_EX`, `MemToReg_EX`  in  1 each  EX writes rd / EX is a load.
- `rdn_MEM`, `RegWrite_MEM`  in  5, 1  MEM destination.
- `rdn_WB`, `RegWrite_WB`  in  5, 1  WB destination.
- `Redirect_EX`  in  1  taken branch/jump resolved in EX (PC reloads next edge).
- `StallIF`, `StallID`  out  1 each  hold PC / hold IF→ID register.
- `EnableID`  out  1  IF→ID register enable (= !StallID).
- `FlushD`, `FlushE`  out  1 each  clear ID / EX pipe registers.
- `FwdA_EX`, `FwdB_EX`  out  2 each  00 register file, 01 WB Result, 10 MEM ALUOut.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating perf counters.

## Operation
- Register x0 never creates a hazard or forward: any compare with rn==0 is false.
- Forwarding (EX operand A uses rs1n_EX, B uses rs2n_EX):
  - select 10 if RegWrite_MEM and rdn_MEM matches;
  - else 01 if RegWrite_WB and rdn_WB matches;
  - else 00. MEM has priority over WB.
- Load-use: `lu = RegWrite_EX & MemToReg_EX & rdn_EX!=0 & (rdn_EX==rs1n_ID | rdn_EX==rs2n_ID)`. On `lu`: StallIF=StallID=1, EnableID=0, FlushE=1 for that cycle (one bubble).
- FSM states:
  - RUN: on Redirect_EX, assert FlushD=FlushE=1 the same cycle. If FLUSH_CYCLES>1, go to FLUSH with `fcnt=FLUSH_CYCLES-1`.
  - FLUSH: FlushD=FlushE=1 and `fcnt` decrements. Return to RUN when `fcnt` reaches 1 on the current cycle. Redirect_EX is ignored while in FLUSH.
- Priority: a redirect (RUN) or the FLUSH state overrides load-use/RAW stalls. In those cycles StallIF=StallID=0 so the PC takes the new target.
- Counters: `stall_cnt` +1 per cycle with StallIF=1; `flush_cnt` +1 per cycle with FlushD=1. Both saturate at all-ones and never wrap.

## Timing
- Stall, flush and forward outputs are combinational from inputs and registered state, valid in the same cycle. There is no added latency.
- Only `state`, `fcnt` and the counters are registered and update on posedge clk.
- Reset: state=RUN, fcnt=0, counters=0. With Redirect_EX=0 and no hazard, outputs are StallIF=StallID=FlushD=FlushE=0, EnableID=1, Fwd=00.
- `rst` asserted mid-FLUSH returns the FSM to RUN at the next edge. Flush outputs for the rest of that reset cycle follow the pre-reset state.
- Load-use and redirect in the same cycle: redirect wins, so no stall and FlushE=1.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as above; only load-use stalls.
- Not defined: FwdA/FwdB are tied to 00. Instead, stall (StallIF=StallID=1, FlushE=1) whenever rs1n_ID/rs2n_ID (nonzero) matches a writing rdn_EX, rdn_MEM or rdn_WB. WB is included because the register file reads the pre-write value in the same cycle.

## Structure
- Shared package `hazard_pkg`: FSM state enum (RUN, FLUSH), forward-select constants (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
- One sub-module, `sat_counter` (CNT_W, inc, rst), instantiated twice for the perf counters.
- Remaining logic stays flat in `hazard_ctrl`.

## Test plan
- Reset, then idle inputs → outputs at reset values, EnableID=1, counters 0 after 10 cycles.
- rdn_MEM=5, RegWrite_MEM=1, rdn_WB=5, RegWrite_WB=1, rs1n_EX=5 → FwdA_EX=10. Drop RegWrite_MEM → FwdA_EX=01. With rs1n_EX=0 → 00.
- Load in EX (rdn_EX=7, MemToReg_EX=1, RegWrite_EX=1), rs2n_ID=7 for 1 cycle → StallIF=StallID=FlushE=1, EnableID=0 for one cycle; stall_cnt=1.
- FLUSH_CYCLES=2, Redirect_EX pulse → FlushD=FlushE=1 for exactly 2 cycles, a second pulse in cycle 2 is ignored, flush_cnt=2.
- Redirect_EX and load-use together → StallIF=0, FlushE=1, FlushD=1.
- Without HAZARD_FWD_EN: rdn_WB=3, RegWrite_WB=1, rs1n_ID=3 → StallIF=1, Fwd=00. With CNT_W=4, 20 stall cycles → stall_cnt=15.
